// File: rtl/fsm_arb_pkg.sv
// Shared types for the four-agent round-robin arbiter.
// State enum, agent count and the owner/pointer index type.
package fsm_arb_pkg;

  localparam int N_AGENTS = 4;

  typedef logic [1:0] idx_t;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first eligible agent at ptr, ptr+1, ...
// Purely combinational; pick is one-hot and matches idx when valid.
module rr_pick
  import fsm_arb_pkg::*;
(
  input  logic [N_AGENTS-1:0] elig,
  input  idx_t                ptr,
  output logic [N_AGENTS-1:0] pick,
  output idx_t                idx,
  output logic                valid
);

  idx_t cand;

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < N_AGENTS; i++) begin
      cand = ptr + idx_t'(i);
      if (!valid && elig[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
    if (valid) pick[idx] = 1'b1;
  end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Four-agent round-robin arbiter with a per-grant hold limit.
// A revoked agent stays locked out until it drops its request.
module fsm_rr_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req_0,
  input  logic       req_1,
  input  logic       req_2,
  input  logic       req_3,
  output logic       gnt_0,
  output logic       gnt_1,
  output logic       gnt_2,
  output logic       gnt_3,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  localparam int HW =
    (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] LIM =
    HW'((MAX_HOLD < 1) ? 0 : MAX_HOLD - 1);
  localparam bit LIMIT_ON = (MAX_HOLD != 0);

  state_t st, st_n;
  idx_t ptr, ptr_n;
  idx_t own, own_n;
  logic [N_AGENTS-1:0] req, elig;
  logic [N_AGENTS-1:0] lock, lock_n;
  logic [N_AGENTS-1:0] gnt, gnt_n;
  logic [HW-1:0] hold, hold_n;
  logic busy_r, busy_n;
  logic to_r, to_n;

  logic [N_AGENTS-1:0] pick;
  idx_t pick_idx;
  logic pick_vld;

  assign req  = {req_3, req_2, req_1, req_0};
  assign elig = req & ~lock;

  rr_pick u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .pick  (pick),
    .idx   (pick_idx),
    .valid (pick_vld)
  );

  always_comb begin
    st_n   = st;
    ptr_n  = ptr;
    own_n  = own;
    gnt_n  = gnt;
    hold_n = hold;
    to_n   = 1'b0;
    lock_n = lock & req;
    unique case (st)
      IDLE: begin
        if (pick_vld) begin
          gnt_n  = pick;
          own_n  = pick_idx;
          hold_n = '0;
          st_n   = GRANT;
        end else begin
          gnt_n = '0;
        end
      end
      GRANT: begin
        if (!req[own]) begin
          gnt_n = '0;
          ptr_n = own + idx_t'(1);
          st_n  = IDLE;
        end else if (LIMIT_ON && hold == LIM) begin
          gnt_n       = '0;
          to_n        = 1'b1;
          lock_n[own] = 1'b1;
          ptr_n       = own + idx_t'(1);
          st_n        = IDLE;
        end else if (hold != '1) begin
          hold_n = hold + 1'b1;
        end
      end
    endcase
    busy_n = |gnt_n;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      st     <= IDLE;
      ptr    <= '0;
      own    <= '0;
      gnt    <= '0;
      hold   <= '0;
      lock   <= '0;
      busy_r <= 1'b0;
      to_r   <= 1'b0;
    end else begin
      st     <= st_n;
      ptr    <= ptr_n;
      own    <= own_n;
      gnt    <= gnt_n;
      hold   <= hold_n;
      lock   <= lock_n;
      busy_r <= busy_n;
      to_r   <= to_n;
    end
  end

  assign gnt_0   = gnt[0];
  assign gnt_1   = gnt[1];
  assign gnt_2   = gnt[2];
  assign gnt_3   = gnt[3];
  assign owner   = own;
  assign busy    = busy_r;
  assign timeout = to_r;

endmodule

// File: doc/fsm_rr_arbiter.md
# fsm_rr_arbiter

Four-agent round-robin arbiter with per-grant hold limit, for sharing a single resource between agents 0–3. It replaces fixed priority with a rotating pointer so no agent starves. It revokes a grant held longer than MAX_HOLD cycles and locks the offending agent out until it drops its request. Grants are registered, one-hot and mutually exclusive, and drive the shared resource's select/enable.

## Interface
- MAX_HOLD, default 16: maximum consecutive cycles one grant may stay high; 0 disables the limit.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req_0..req_3  input  1 each  active-high request; level, held for as long as the agent wants the resource.
- gnt_0..gnt_3  output  1 each  active-high registered grant; at most one high.
- owner  output  2  index of the current or most recent grant holder.
- busy  output  1  high while any gnt is high.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- State machine in fsm_arb_pkg: IDLE, GRANT.
- Eligible set: req_i AND NOT lock_i.
- Pointer ptr[1:0]: the first agent searched. The picker chooses the first eligible agent at ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- IDLE:
  - If the eligible set is non-empty, register the picked gnt, set owner, set busy, clear hold_cnt, go to GRANT.
  - Otherwise stay in IDLE with all gnt low.
- GRANT, owner's req low: clear gnt, set ptr = owner+1 (mod 4), go to IDLE.
- GRANT, MAX_HOLD ≠ 0 and hold_cnt == MAX_HOLD-1 with owner's req still high:
  - Clear gnt and pulse timeout.
  - Set lock_owner and ptr = owner+1, go to IDLE.
- GRANT, otherwise: hold_cnt increments and gnt holds.
- lock_i clears on any cycle where req_i is sampled low.
- A locked agent is never picked, even if it is the only requester.
- hold_cnt width is $clog2(MAX_HOLD+1), minimum 1. It saturates and never wraps.
- owner keeps its value in IDLE. ptr changes only on release or revoke.
- Simultaneous requests: rotation order decides; there is no fixed priority.
- Another agent requesting during GRANT does not pre-empt the owner.
- Reset values:
  - state = IDLE; gnt_0..gnt_3 = 0; owner = 0; busy = 0; timeout = 0.
  - ptr = 0; lock = 4'b0000; hold_cnt = 0.
  - Reset mid-grant drops gnt immediately (asynchronous).

## Timing
- Grant latency: req sampled high at edge k in IDLE gives gnt high after edge k. This is one cycle from the request asserting before edge k.
- Release: owner's req sampled low at edge k gives gnt low after edge k. The earliest next grant is after edge k+1, so there is always exactly one all-low cycle between two owners.
- Hold limit: gnt is high for exactly MAX_HOLD cycles.
- timeout is high in the first cycle gnt is low after a revoke.
- busy equals the OR of all gnt bits, registered with them, so it shows no glitch.
- Deassertion of reset_n is synchronised externally. The first arbitration happens on the first edge after reset_n is seen high.

## Structure
- Package fsm_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - N_AGENTS = 4;
  - the owner/pointer index type.
- Sub-module rr_pick:
  - Combinational, 4-bit eligible vector and 2-bit ptr in.
  - Out: one-hot 4-bit pick, 2-bit index, valid.
- Top level holds the FSM, ptr, lock and hold_cnt registers, and the output registers.

## Test plan
- Reset then single requester: reset_n low mid-grant then high, req_2=1 → gnt_2 high one cycle later; owner=2, busy=1. Asserting reset_n low forces all gnt low at once.
- Rotation: ptr=0 with req_0..req_3 all held high, each dropping after 3 cycles of grant → grant order 0,1,2,3,0. There is one all-low cycle between owners.
- Simultaneous after release: agent 1 releases while req_0 and req_3 are high → next grant is gnt_3 (search from ptr=2), not gnt_0.
- Hold limit: MAX_HOLD=4, req_1 stuck high → gnt_1 high exactly 4 cycles, then timeout pulses once.
  - While req_1 stays high it is never re-granted; req_2 arriving later is granted.
  - After req_1 drops for one cycle and rises again it is granted.
- Lone locked requester: MAX_HOLD=4, only req_0 stuck high after a timeout → all gnt stay low and busy=0 until req_0 drops.
- MAX_HOLD=0: req_3 held for 100 cycles → gnt_3 stays high throughout; timeout is never asserted.
